// File: rtl/uart_tx_feeder_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_pkg
// Shared definitions for the UART transmit feeder slice:
//   DEPTH_DEFAULT  - default FIFO depth in bytes (power of two, 4..256)
//   OVF_CNT_W      - width of the optional dropped-write counter
//   feeder_state_t - launch FSM encoding (IDLE=0, LAUNCH=1, WAIT=2)
// Optional feature macro used by this slice: UART_TX_FEEDER_OVF_CNT_EN
// -----------------------------------------------------------------------------
package uart_tx_feeder_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int OVF_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO with registered full/empty/level flags. Flags reflect
// the push/pop that happened on the previous rising edge.
// A push is accepted when the FIFO is not full, or when a pop happens in the
// same cycle (the slot being vacated is reused).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   i_wr_data  in   byte to store
//   i_wr_en    in   write request
//   i_rd_en    in   pop request (ignored while empty)
//   o_rd_data  out  head byte (valid while not empty)
//   o_full     out  FIFO holds DEPTH bytes
//   o_empty    out  FIFO holds 0 bytes
//   o_level    out  byte count, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level_nxt;

  assign w_pop  = i_rd_en & ~r_empty;
  assign w_push = i_wr_en & (~r_full | w_pop);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Storage is not reset; the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // When full with a simultaneous push and pop, wr_ptr == rd_ptr: the head is
  // read here before the edge overwrites that slot.
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Queues bytes in a FIFO and hands them one at a time to a UART transmitter.
// The transmitter raises tx_busy combinationally with din_vld and holds it
// until its stop bit ends.
//
// Optional feature: define UART_TX_FEEDER_OVF_CNT_EN to add output ovf_cnt,
// a saturating count of writes dropped because the FIFO was full.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_data  in   byte to queue
//   wr_en    in   write strobe (dropped while full unless a pop coincides)
//   full     out  FIFO holds DEPTH bytes (registered)
//   empty    out  FIFO holds 0 bytes (registered)
//   level    out  byte count (registered)
//   din      out  byte to transmitter, held until the next pop
//   din_vld  out  one-cycle launch strobe
//   tx_busy  in   transmitter busy
//   ovf_cnt  out  dropped-write count (only with UART_TX_FEEDER_OVF_CNT_EN)
//
// state  | meaning
// IDLE   | waiting for queued data and an idle transmitter; pops head into din
// LAUNCH | din_vld high for this single cycle
// WAIT   | transmitter busy with the launched byte
// -----------------------------------------------------------------------------
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               din,
  output logic                     din_vld,
  input  logic                     tx_busy
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]     ovf_cnt
`endif
);

  feeder_state_t r_state;
  feeder_state_t w_state_nxt;

  logic [7:0] r_din;
  logic [7:0] w_head;
  logic       w_pop;
  logic       w_din_vld;
  logic       w_full;
  logic       w_empty;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_data (wr_data),
    .i_wr_en   (wr_en),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_din_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // tx_busy is ignored here: it rises with din_vld by definition.
        w_din_vld   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_din <= 8'h00;
    else if (w_pop) r_din <= w_head;
  end

  assign din     = r_din;
  assign din_vld = w_din_vld;
  assign full    = w_full;
  assign empty   = w_empty;

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic                 w_wr_drop;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // A write while full is only dropped if no pop frees a slot that cycle.
  assign w_wr_drop = wr_en & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_wr_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int D = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           wr_data = 8'h00;
  logic                 wr_en = 1'b0;
  logic                 full;
  logic                 empty;
  logic [$clog2(D):0]   level;
  logic [7:0]           din;
  logic                 din_vld;
  logic                 tx_busy;
`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [7:0]           ovf_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_tx_feeder #(.DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .din     (din),
    .din_vld (din_vld),
    .tx_busy (tx_busy)
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles starting with the din_vld cycle.
  logic stall = 1'b0;
  int   busy_len = 1;
  int   busy_cnt;
  int   cyc = 0;

  assign tx_busy = stall | din_vld | (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              busy_cnt <= 0;
    else if (din_vld)        busy_cnt <= busy_len - 1;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end

  // Launch monitor: records launched bytes, their cycle, and the distance from
  // the last falling edge of tx_busy.
  logic [7:0] q_out[$];
  int         q_t[$];
  int         q_gap[$];
  logic       prev_vld = 1'b0;
  logic       prev_busy = 1'b0;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    if (din_vld) begin
      n_vec++;
      if (prev_vld) begin
        n_err++;
        $display("FAIL din_vld_consecutive: din_vld high two cycles in a row at cycle %0d (required single pulse)", cyc);
      end
      q_out.push_back(din);
      q_t.push_back(cyc);
      q_gap.push_back(cyc - fall_cyc);
    end
    if (!tx_busy && prev_busy) fall_cyc = cyc;
    prev_vld  = din_vld;
    prev_busy = tx_busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_out.delete();
    q_t.delete();
    q_gap.delete();
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int i = 0; i < 1000 && q < 3; i++) begin
      tick();
      if (!din_vld && !tx_busy && empty) q++;
      else q = 0;
    end
    n_vec++;
    if (q < 3) begin
      n_err++;
      $display("FAIL quiet_timeout: design still active after 1000 cycles (required idle)");
    end
  endtask

  task automatic wait_launches(input int n, input int budget);
    for (int i = 0; i < budget && q_out.size() < n; i++) tick();
    n_vec++;
    if (q_out.size() < n) begin
      n_err++;
      $display("FAIL launch_timeout: got %0d launches, required %0d within %0d cycles", q_out.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b required 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b required 0", full); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d required 0", level); end
    n_vec++; if (din !== 8'h00) begin n_err++; $display("FAIL reset_din: got %h required 00", din); end
    n_vec++; if (din_vld !== 1'b0) begin n_err++; $display("FAIL reset_din_vld: got %b required 0", din_vld); end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL reset_ovf_cnt: got %0d required 0", ovf_cnt); end
`endif
    rst_n = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (din_vld !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: din_vld=%b empty=%b required 0/1", din_vld, empty);
    end
  endtask

  task automatic test_single();
    clear_q();
    busy_len = 1;
    wr_data = 8'hA5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_vec++; if (level !== 5'd1 || empty !== 1'b0) begin n_err++; $display("FAIL single_queued: level=%0d empty=%b required 1/0", level, empty); end
    n_vec++; if (din_vld !== 1'b0) begin n_err++; $display("FAIL single_early_vld: got %b required 0", din_vld); end
    tick();
    n_vec++; if (din_vld !== 1'b1) begin n_err++; $display("FAIL single_vld: got %b required 1", din_vld); end
    n_vec++; if (din !== 8'hA5) begin n_err++; $display("FAIL single_din: got %h required a5", din); end
    n_vec++; if (empty !== 1'b1 || level !== 5'd0) begin n_err++; $display("FAIL single_empty: empty=%b level=%0d required 1/0", empty, level); end
    tick();
    n_vec++; if (din_vld !== 1'b0 || din !== 8'hA5) begin n_err++; $display("FAIL single_hold: din_vld=%b din=%h required 0/a5", din_vld, din); end
    wait_quiet();
    n_vec++; if (q_out.size() != 1) begin n_err++; $display("FAIL single_count: got %0d launches required 1", q_out.size()); end
  endtask

  task automatic test_seq3();
    clear_q();
    busy_len = 100;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(i + 1); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    wait_launches(3, 600);
    if (q_out.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (q_out[k] !== 8'(k + 1)) begin n_err++; $display("FAIL seq3_order[%0d]: got %h required %h", k, q_out[k], 8'(k + 1)); end
      end
      for (int k = 1; k < 3; k++) begin
        n_vec++;
        if (q_gap[k] != 2) begin n_err++; $display("FAIL seq3_gap[%0d]: got %0d cycles required 2", k, q_gap[k]); end
        n_vec++;
        if (q_t[k] - q_t[k-1] != 102) begin n_err++; $display("FAIL seq3_spacing[%0d]: got %0d cycles required 102", k, q_t[k] - q_t[k-1]); end
      end
    end
    wait_quiet();
    busy_len = 1;
  endtask

  task automatic test_full();
    clear_q();
    busy_len = 1;
    stall = 1'b1;
    tick();
    for (int i = 0; i < D + 2; i++) begin
      wr_data = 8'(8'h10 + i); wr_en = 1'b1;
      tick();
      if (i == D - 2) begin
        n_vec++;
        if (full !== 1'b0 || level !== 5'(D - 1)) begin n_err++; $display("FAIL full_almost: full=%b level=%0d required 0/%0d", full, level, D - 1); end
      end
    end
    wr_en = 1'b0;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b required 1", full); end
    n_vec++; if (level !== 5'(D)) begin n_err++; $display("FAIL full_level: got %0d required %0d", level, D); end
    n_vec++; if (q_out.size() != 0) begin n_err++; $display("FAIL full_stalled_launch: got %0d launches required 0", q_out.size()); end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd2) begin n_err++; $display("FAIL full_ovf_cnt: got %0d required 2", ovf_cnt); end
`endif
    stall = 1'b0;
    wait_launches(D, 300);
    wait_quiet();
    n_vec++; if (q_out.size() != D) begin n_err++; $display("FAIL full_drain_count: got %0d required %0d", q_out.size(), D); end
    for (int i = 0; i < D && i < q_out.size(); i++) begin
      n_vec++;
      if (q_out[i] !== 8'(8'h10 + i)) begin n_err++; $display("FAIL full_drain[%0d]: got %h required %h", i, q_out[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_full_pop();
    clear_q();
    busy_len = 1;
    stall = 1'b1;
    tick();
    for (int i = 0; i < D; i++) begin
      wr_data = 8'(8'h20 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fpop_prefull: got %b required 1", full); end
    stall = 1'b0;
    wr_data = 8'hEE; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_vec++; if (level !== 5'(D) || full !== 1'b1) begin n_err++; $display("FAIL fpop_level: level=%0d full=%b required %0d/1", level, full, D); end
    n_vec++; if (din_vld !== 1'b1 || din !== 8'h20) begin n_err++; $display("FAIL fpop_launch: din_vld=%b din=%h required 1/20", din_vld, din); end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd2) begin n_err++; $display("FAIL fpop_ovf_cnt: got %0d required 2", ovf_cnt); end
`endif
    wait_launches(D + 1, 300);
    wait_quiet();
    n_vec++; if (q_out.size() != D + 1) begin n_err++; $display("FAIL fpop_count: got %0d required %0d", q_out.size(), D + 1); end
    for (int i = 0; i < D && i < q_out.size(); i++) begin
      n_vec++;
      if (q_out[i] !== 8'(8'h20 + i)) begin n_err++; $display("FAIL fpop_drain[%0d]: got %h required %h", i, q_out[i], 8'(8'h20 + i)); end
    end
    if (q_out.size() > D) begin
      n_vec++;
      if (q_out[D] !== 8'hEE) begin n_err++; $display("FAIL fpop_last: got %h required ee", q_out[D]); end
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    clear_q();
    busy_len = 1;
    stall = 1'b0;
    for (int i = 0; i < 2000 && q_out.size() < 3 * D; i++) begin
      if (sent < 3 * D && !full) begin
        wr_data = 8'(sent * 7 + 3); wr_en = 1'b1;
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    wait_quiet();
    n_vec++; if (q_out.size() != 3 * D) begin n_err++; $display("FAIL wrap_count: got %0d required %0d", q_out.size(), 3 * D); end
    for (int i = 0; i < 3 * D && i < q_out.size(); i++) begin
      n_vec++;
      if (q_out[i] !== 8'(i * 7 + 3)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h required %h", i, q_out[i], 8'(i * 7 + 3)); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    busy_len = 100;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h30 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    repeat (5) tick();
    n_vec++; if (level !== 5'd5 || din_vld !== 1'b0 || tx_busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre: level=%0d din_vld=%b tx_busy=%b required 5/0/1", level, din_vld, tx_busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (empty !== 1'b1 || full !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL rmid_flags: empty=%b full=%b level=%0d required 1/0/0", empty, full, level); end
    n_vec++; if (din !== 8'h00 || din_vld !== 1'b0) begin n_err++; $display("FAIL rmid_out: din=%h din_vld=%b required 00/0", din, din_vld); end
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_ovf_cnt: got %0d required 0", ovf_cnt); end
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    clear_q();
    repeat (20) tick();
    n_vec++; if (q_out.size() != 0) begin n_err++; $display("FAIL rmid_no_launch: got %0d launches required 0", q_out.size()); end
    wr_data = 8'h5A; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_launches(1, 20);
    if (q_out.size() >= 1) begin
      n_vec++;
      if (q_out[0] !== 8'h5A) begin n_err++; $display("FAIL rmid_new: got %h required 5a", q_out[0]); end
    end
    wait_quiet();
    busy_len = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_seq3();
    test_full();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..256.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port wr_data, input, 8, byte to queue for transmission.
REQ-005 SHALL have port wr_en, input, 1, write strobe for wr_data.
REQ-006 SHALL have port full, output, 1, FIFO holds DEPTH bytes.
REQ-007 SHALL have port empty, output, 1, FIFO holds 0 bytes.
REQ-008 SHALL have port level, output, log2(DEPTH)+1, current byte count.
REQ-009 SHALL have port din, output, 8, byte to UART transmitter.
REQ-010 SHALL have port din_vld, output, 1, one-cycle launch strobe to transmitter.
REQ-011 SHALL have port tx_busy, input, 1, transmitter busy; rises combinationally with din_vld and stays high until the stop bit ends.

Function
REQ-012 SHALL store bytes first-in first-out; write accepted when wr_en=1 and full=0; wr_en while full drops the byte with no state change.
REQ-013 SHALL update full/empty/level registered, in the cycle after the causing write/pop.
REQ-014 SHALL run FSM IDLE -> LAUNCH -> WAIT -> IDLE.
REQ-015 IDLE: when empty=0 and tx_busy=0, pop head byte into din register, go to LAUNCH.
REQ-016 LAUNCH: din_vld=1 for exactly one cycle, din stable; go to WAIT.
REQ-017 WAIT: stay while tx_busy=1; on tx_busy=0 go to IDLE.
REQ-018 din_vld SHALL never be high in any state except LAUNCH and never on two consecutive cycles.
REQ-019 din SHALL hold the last launched byte until the next pop.
REQ-020 Simultaneous write and pop SHALL leave level unchanged; a write when full with a pop in the same cycle is accepted.
REQ-021 A write into an empty FIFO SHALL reach din_vld no earlier than 2 cycles later (pop cycle, launch cycle).
REQ-022 Pointers SHALL wrap modulo DEPTH with no lost or duplicated byte.
REQ-023 Gap between end of tx_busy and next din_vld SHALL be 2 cycles when data is queued.

Reset
REQ-024 On rst_n=0: FSM=IDLE, pointers=0, level=0, empty=1, full=0, din=8'h00, din_vld=0.
REQ-025 Reset mid-frame SHALL discard queued bytes; after release, no din_vld until a new write.

Configuration
REQ-026 Macro UART_TX_FEEDER_OVF_CNT_EN defined: output ovf_cnt (8 bits) counts writes dropped while full, saturating at 255, reset to 0.
REQ-027 Macro undefined: no ovf_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-028 Shared package/param file SHALL hold default DEPTH, FSM state encodings (IDLE=0, LAUNCH=1, WAIT=2) and the overflow counter width.
REQ-029 Storage and pointers SHALL be one sub-module, uart_tx_fifo (sync FIFO, registered flags); FSM stays in uart_tx_feeder.

Verification
REQ-030 Write 8'hA5 into empty FIFO, tx_busy=0 -> din_vld one cycle 2 cycles later, din=8'hA5, empty=1.
REQ-031 Write 3 bytes 01,02,03 back-to-back, transmitter model busy for 100 cycles each -> three din_vld pulses in order, each 2 cycles after tx_busy falls.
REQ-032 Stall tx_busy=1, write DEPTH+2 bytes -> full=1, level=DEPTH, last 2 dropped, ovf_cnt=2 when macro defined.
REQ-033 Write every cycle while popping across 3*DEPTH bytes -> pointer wrap, output sequence equals input sequence.
REQ-034 Assert rst_n=0 in WAIT with 5 bytes queued -> all outputs at reset values, no din_vld after release until new write.
REQ-035 Write while full with a pop in the same cycle -> byte accepted, level stays DEPTH, ovf_cnt unchanged.
